// File: rtl/fetch_unit_buffered_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_buffered_if
// Bundles every non-clock signal of the buffered fetch unit: redirect input,
// ITLB lookup, instruction-cache lookup, refill req/ack to the memory arbiter,
// sticky ITLB-fault report and the fetch-queue head presented to decode.
//   master : the fetch unit's view (drives the *_o signals)
//   slave  : the surrounding core/memory view (drives the *_i signals)
// ----------------------------------------------------------------------------
interface fetch_unit_buffered_if #(
   parameter int PHYS_W   = 20,
   parameter int FQ_DEPTH = 4
);
   localparam int CNT_W = $clog2(FQ_DEPTH + 1);

   logic              redirect_i;
   logic [31:0]       redirect_pc_i;
   logic [31:0]       tlb_vaddr_o;
   logic [PHYS_W-1:0] tlb_paddr_i;
   logic              tlb_ready_i;
   logic              tlb_miss_i;
   logic [PHYS_W-1:0] icache_addr_o;
   logic              icache_hit_i;
   logic [31:0]       icache_data_i;
   logic              mem_req_o;
   logic [PHYS_W-1:0] mem_addr_o;
   logic              mem_ack_i;
   logic              itlb_fault_o;
   logic [31:0]       fault_pc_o;
   logic              inst_valid_o;
   logic [31:0]       inst_o;
   logic [31:0]       inst_pc_o;
   logic              inst_ready_i;
   logic [CNT_W-1:0]  fq_count_o;

   modport master (
      input  redirect_i, redirect_pc_i, tlb_paddr_i, tlb_ready_i, tlb_miss_i,
             icache_hit_i, icache_data_i, mem_ack_i, inst_ready_i,
      output tlb_vaddr_o, icache_addr_o, mem_req_o, mem_addr_o, itlb_fault_o,
             fault_pc_o, inst_valid_o, inst_o, inst_pc_o, fq_count_o
   );

   modport slave (
      output redirect_i, redirect_pc_i, tlb_paddr_i, tlb_ready_i, tlb_miss_i,
             icache_hit_i, icache_data_i, mem_ack_i, inst_ready_i,
      input  tlb_vaddr_o, icache_addr_o, mem_req_o, mem_addr_o, itlb_fault_o,
             fault_pc_o, inst_valid_o, inst_o, inst_pc_o, fq_count_o
   );
endinterface

// File: rtl/fetch_unit_buffered.sv
// ----------------------------------------------------------------------------
// fetch_unit_buffered
// Instruction-fetch front end. Holds the PC, looks it up through the ITLB and
// instruction cache, sequences line refills over a req/ack handshake, and
// buffers fetched {pc, instruction} pairs in a small FIFO feeding decode.
// Supports redirect/flush (also while a refill is outstanding), a sticky ITLB
// fault report and decode backpressure.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (master) : redirect, ITLB, icache, refill req/ack, fault report,
//                  fetch-queue head and occupancy (see fetch_unit_buffered_if)
// ----------------------------------------------------------------------------
module fetch_unit_buffered #(
   parameter int          PHYS_W     = 20,
   parameter int          FQ_DEPTH   = 4,
   parameter int          LINE_BYTES = 16,
   parameter logic [31:0] RESET_PC   = 32'h1000
) (
   input logic                   clock,
   input logic                   reset,
   fetch_unit_buffered_if.master bus
);
   localparam int                PTR_W     = $clog2(FQ_DEPTH);
   localparam int                CNT_W     = $clog2(FQ_DEPTH + 1);
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FQ_DEPTH);
   localparam logic [PHYS_W-1:0] LINE_MASK = ~(PHYS_W'(LINE_BYTES - 1));

   typedef enum logic [1:0] {ST_RUN, ST_REFILL, ST_DRAIN, ST_FAULT} state_t;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic              mem_req_q, mem_req_d;
   logic [PHYS_W-1:0] mem_addr_q, mem_addr_d;
   logic              fault_q, fault_d;
   logic [31:0]       fault_pc_q, fault_pc_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              inst_valid_q, inst_valid_d;
   logic [31:0]       inst_q, inst_d;
   logic [31:0]       inst_pc_q, inst_pc_d;
   logic [31:0]       fq_inst_q [FQ_DEPTH];
   logic [31:0]       fq_pc_q   [FQ_DEPTH];
   logic              push, pop, space;

   // Control FSM: lookup decisions, refill sequencing, fault and redirect.
   always_comb begin : ctrl_comb
      state_d    = state_q;
      pc_d       = pc_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      push       = 1'b0;
      pop        = inst_valid_q & bus.inst_ready_i;
      space      = (count_q < DEPTH_C) | pop;

      case (state_q)
         ST_RUN: begin
            // A full queue with no pop suppresses the whole lookup, including
            // fault and refill decisions, so the PC simply holds.
            if (space && bus.tlb_ready_i) begin
               if (bus.tlb_miss_i) begin
                  state_d    = ST_FAULT;
                  fault_d    = 1'b1;
                  fault_pc_d = pc_q;
               end else if (bus.icache_hit_i) begin
                  push = 1'b1;
                  pc_d = pc_q + 32'd4;
               end else begin
                  state_d    = ST_REFILL;
                  mem_addr_d = bus.tlb_paddr_i & LINE_MASK;
                  mem_req_d  = 1'b1;
               end
            end
         end
         ST_REFILL, ST_DRAIN: begin
            if (bus.mem_ack_i) begin
               mem_req_d = 1'b0;
               state_d   = ST_RUN;
            end
         end
         default: begin
         end
      endcase

      // Redirect wins over everything. An outstanding request is never
      // withdrawn: without an ack in this cycle we park in DRAIN (this also
      // covers a second redirect arriving while already draining).
      if (bus.redirect_i) begin
         push       = 1'b0;
         pop        = 1'b0;
         pc_d       = bus.redirect_pc_i;
         fault_d    = 1'b0;
         fault_pc_d = fault_pc_q;
         mem_addr_d = mem_addr_q;
         if ((state_q == ST_REFILL || state_q == ST_DRAIN) && !bus.mem_ack_i) begin
            state_d   = ST_DRAIN;
            mem_req_d = 1'b1;
         end else begin
            state_d   = ST_RUN;
            mem_req_d = 1'b0;
         end
      end
   end

   // Fetch queue pointers/occupancy and the registered head entry.
   always_comb begin : fifo_comb
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      inst_valid_d = inst_valid_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      if (bus.redirect_i) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         inst_valid_d = 1'b0;
      end else begin
         wr_ptr_d     = wr_ptr_q + PTR_W'(push);
         rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
         count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
         inst_valid_d = (count_d != '0);
         // When the queue would otherwise be empty the new head is the entry
         // being written this cycle, so bypass it instead of reading storage.
         if ((count_q - CNT_W'(pop)) == '0) begin
            if (push) begin
               inst_d    = bus.icache_data_i;
               inst_pc_d = pc_q;
            end
         end else begin
            inst_d    = fq_inst_q[rd_ptr_d];
            inst_pc_d = fq_pc_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         fault_q      <= 1'b0;
         fault_pc_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         fault_q      <= fault_d;
         fault_pc_q   <= fault_pc_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   // Queue storage and head data carry no reset; inst_valid_o qualifies them.
   always_ff @(posedge clock) begin
      if (push) begin
         fq_inst_q[wr_ptr_q] <= bus.icache_data_i;
         fq_pc_q[wr_ptr_q]   <= pc_q;
      end
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
   end

   assign bus.tlb_vaddr_o   = pc_q;
   assign bus.icache_addr_o = bus.tlb_paddr_i;
   assign bus.mem_req_o     = mem_req_q;
   assign bus.mem_addr_o    = mem_addr_q;
   assign bus.itlb_fault_o  = fault_q;
   assign bus.fault_pc_o    = fault_pc_q;
   assign bus.inst_valid_o  = inst_valid_q;
   assign bus.inst_o        = inst_q;
   assign bus.inst_pc_o     = inst_pc_q;
   assign bus.fq_count_o    = count_q;
endmodule

// File: tb/tb_fetch_unit_buffered.sv
module tb_fetch_unit_buffered;
   localparam int PHYS_W     = 20;
   localparam int FQ_DEPTH   = 4;
   localparam int LINE_BYTES = 16;
   localparam int LB         = $clog2(LINE_BYTES);

   typedef enum int {M_RUN, M_REFILL, M_DRAIN, M_FAULT} mmode_t;

   logic clock = 1'b0;
   logic reset = 1'b1;

   fetch_unit_buffered_if #(.PHYS_W(PHYS_W), .FQ_DEPTH(FQ_DEPTH)) bus_if ();

   fetch_unit_buffered #(
      .PHYS_W(PHYS_W), .FQ_DEPTH(FQ_DEPTH), .LINE_BYTES(LINE_BYTES),
      .RESET_PC(32'h1000)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus_if)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Scoreboard of expected deliveries: {pc, instruction}, oldest first.
   logic [63:0] sb[$];

   // Reference model state.
   mmode_t            m_mode;
   logic [31:0]       m_pc, m_fpc;
   logic [PHYS_W-1:0] m_addr;
   bit                m_req, m_fault;
   int                m_cnt;
   bit                line_v [65536];
   int                req_age;
   int                ack_lat;
   bit                rand_lat;

   function automatic logic [31:0] word_at(logic [PHYS_W-1:0] pa);
      return (32'(pa) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_RUN;
      m_pc    = 32'h1000;
      m_fpc   = 32'h0;
      m_addr  = '0;
      m_req   = 1'b0;
      m_fault = 1'b0;
      m_cnt   = 0;
      req_age = 0;
      sb.delete();
   endtask

   task automatic do_reset();
      @(negedge clock); #1;
      reset                = 1'b1;
      bus_if.redirect_i    = 1'b0;
      bus_if.redirect_pc_i = 32'h0;
      bus_if.tlb_paddr_i   = '0;
      bus_if.tlb_ready_i   = 1'b0;
      bus_if.tlb_miss_i    = 1'b0;
      bus_if.icache_hit_i  = 1'b0;
      bus_if.icache_data_i = 32'h0;
      bus_if.mem_ack_i     = 1'b0;
      bus_if.inst_ready_i  = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      @(posedge clock); #2;
      reset = 1'b0;
   endtask

   // Wait until just after the next active edge to look at registered outputs.
   task automatic settle();
      @(posedge clock); #1;
   endtask

   // One clock of stimulus: hit_mode 0 = cache bitmap, 1 = force hit, 2 = force miss.
   task automatic drive_cycle(bit red, logic [31:0] rpc, bit rdy, bit trdy, bit miss, int hit_mode);
      logic [PHYS_W-1:0] pa;
      bit hit, ack, pop, space;
      @(negedge clock); #1;
      pa  = m_pc[PHYS_W-1:0];
      hit = (hit_mode == 1) ? 1'b1 : (hit_mode == 2) ? 1'b0 : line_v[pa[PHYS_W-1:LB]];
      if (m_req) begin
         req_age++;
         if (rand_lat && req_age == 1) ack_lat = int'($urandom_range(1, 6));
      end else begin
         req_age = 0;
      end
      ack = m_req && (req_age >= ack_lat);
      bus_if.redirect_i    = red;
      bus_if.redirect_pc_i = rpc;
      bus_if.tlb_paddr_i   = pa;
      bus_if.tlb_ready_i   = trdy;
      bus_if.tlb_miss_i    = miss;
      bus_if.icache_hit_i  = hit;
      bus_if.icache_data_i = word_at(pa);
      bus_if.mem_ack_i     = ack;
      bus_if.inst_ready_i  = rdy;
      #2;
      // Outputs reflect the state after the previous edge.
      chk("vaddr",     64'(bus_if.tlb_vaddr_o),   64'(m_pc));
      chk("icache_addr", 64'(bus_if.icache_addr_o), 64'(pa));
      chk("count",     64'(bus_if.fq_count_o),    64'(m_cnt));
      chk("valid",     64'(bus_if.inst_valid_o),  64'(m_cnt != 0));
      chk("mem_req",   64'(bus_if.mem_req_o),     64'(m_req));
      chk("mem_addr",  64'(bus_if.mem_addr_o),    64'(m_addr));
      chk("fault",     64'(bus_if.itlb_fault_o),  64'(m_fault));
      chk("fault_pc",  64'(bus_if.fault_pc_o),    64'(m_fpc));
      // Advance the model across the coming edge.
      pop   = (m_cnt != 0) && rdy;
      space = (m_cnt < FQ_DEPTH) || pop;
      if (ack) line_v[m_addr[PHYS_W-1:LB]] = 1'b1;
      if (red) begin
         sb.delete();
         m_cnt   = 0;
         m_pc    = rpc;
         m_fault = 1'b0;
         if ((m_mode == M_REFILL || m_mode == M_DRAIN) && !ack) begin
            m_mode = M_DRAIN;
         end else begin
            m_mode = M_RUN;
            m_req  = 1'b0;
         end
      end else begin
         if (pop) m_cnt--;
         case (m_mode)
            M_RUN: begin
               if (space && trdy) begin
                  if (miss) begin
                     m_mode  = M_FAULT;
                     m_fault = 1'b1;
                     m_fpc   = m_pc;
                  end else if (hit) begin
                     sb.push_back({m_pc, word_at(pa)});
                     m_cnt++;
                     m_pc = m_pc + 32'd4;
                  end else begin
                     m_mode = M_REFILL;
                     m_req  = 1'b1;
                     m_addr = pa & ~(PHYS_W'(LINE_BYTES - 1));
                  end
               end
            end
            M_REFILL, M_DRAIN: begin
               if (ack) begin
                  m_req  = 1'b0;
                  m_mode = M_RUN;
               end
            end
            default: begin
            end
         endcase
      end
   endtask

   // Monitor: every delivery to decode is matched against the scoreboard.
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clock); #2;
         if (!reset && bus_if.inst_valid_o && bus_if.inst_ready_i && !bus_if.redirect_i) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_underflow actual_pc=%h required=no_delivery at %0t", bus_if.inst_pc_o, $time);
            end else begin
               exp = sb.pop_front();
               chk("head_pc",   64'(bus_if.inst_pc_o), 64'(exp[63:32]));
               chk("head_inst", 64'(bus_if.inst_o),    64'(exp[31:0]));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit red, rdy, trdy, miss;
      logic [31:0] rpc;
      rand_lat = 1'b0;
      ack_lat  = 5;
      bus_if.redirect_i = 1'b0; bus_if.redirect_pc_i = 32'h0; bus_if.tlb_paddr_i = '0;
      bus_if.tlb_ready_i = 1'b0; bus_if.tlb_miss_i = 1'b0; bus_if.icache_hit_i = 1'b0;
      bus_if.icache_data_i = 32'h0; bus_if.mem_ack_i = 1'b0; bus_if.inst_ready_i = 1'b0;
      model_reset();

      // Reset state and streaming hits with decode always ready.
      do_reset();
      chk("rst_valid", 64'(bus_if.inst_valid_o), 64'(0));
      chk("rst_count", 64'(bus_if.fq_count_o),   64'(0));
      chk("rst_req",   64'(bus_if.mem_req_o),    64'(0));
      chk("rst_pc",    64'(bus_if.tlb_vaddr_o),  64'(32'h1000));
      drive_cycle(0, 0, 1, 1, 0, 1);
      settle();
      chk("t1_first_valid", 64'(bus_if.inst_valid_o), 64'(1));
      chk("t1_first_pc",    64'(bus_if.inst_pc_o),    64'(32'h1000));
      repeat (2) drive_cycle(0, 0, 1, 1, 0, 1);
      settle();
      chk("t1_vaddr", 64'(bus_if.tlb_vaddr_o), 64'(32'h100C));
      chk("t1_head",  64'(bus_if.inst_pc_o),   64'(32'h1008));
      chk("t1_count", 64'(bus_if.fq_count_o),  64'(1));

      // Backpressure: fill to depth, then steady pop+push while full.
      do_reset();
      repeat (6) drive_cycle(0, 0, 0, 1, 0, 1);
      settle();
      chk("bp_count", 64'(bus_if.fq_count_o),  64'(4));
      chk("bp_pc",    64'(bus_if.tlb_vaddr_o), 64'(32'h1010));
      repeat (3) drive_cycle(0, 0, 1, 1, 0, 1);
      settle();
      chk("bp_steady_count", 64'(bus_if.fq_count_o),  64'(4));
      chk("bp_steady_pc",    64'(bus_if.tlb_vaddr_o), 64'(32'h101C));
      chk("bp_steady_head",  64'(bus_if.inst_pc_o),   64'(32'h100C));

      // Miss at 0x0123C: line-aligned request held until ack on its 5th cycle.
      drive_cycle(1, 32'h123C, 1, 0, 0, 1);
      drive_cycle(0, 0, 1, 1, 0, 2);
      settle();
      chk("miss_req",  64'(bus_if.mem_req_o),  64'(1));
      chk("miss_addr", 64'(bus_if.mem_addr_o), 64'(20'h01230));
      repeat (4) drive_cycle(0, 0, 1, 1, 0, 1);
      settle();
      chk("miss_req_held",  64'(bus_if.mem_req_o),  64'(1));
      chk("miss_addr_held", 64'(bus_if.mem_addr_o), 64'(20'h01230));
      drive_cycle(0, 0, 1, 1, 0, 1);
      settle();
      chk("miss_req_drop", 64'(bus_if.mem_req_o), 64'(0));
      drive_cycle(0, 0, 0, 1, 0, 1);
      settle();
      chk("miss_refetch_pc", 64'(bus_if.inst_pc_o), 64'(32'h123C));

      // Redirect during refill: request held until ack, then fetch at 0x2000.
      ack_lat = 4;
      drive_cycle(0, 0, 0, 1, 0, 2);
      drive_cycle(1, 32'h2000, 1, 1, 0, 1);
      settle();
      chk("drain_req",   64'(bus_if.mem_req_o),    64'(1));
      chk("drain_count", 64'(bus_if.fq_count_o),   64'(0));
      chk("drain_valid", 64'(bus_if.inst_valid_o), 64'(0));
      repeat (2) drive_cycle(0, 0, 1, 1, 0, 1);
      settle();
      chk("drain_req_held", 64'(bus_if.mem_req_o), 64'(1));
      drive_cycle(0, 0, 1, 1, 0, 1);
      settle();
      chk("drain_req_drop", 64'(bus_if.mem_req_o), 64'(0));
      drive_cycle(0, 0, 0, 1, 0, 1);
      settle();
      chk("drain_next_pc", 64'(bus_if.inst_pc_o), 64'(32'h2000));

      // ITLB fault at 0x1008: older entries still drain, redirect clears it.
      drive_cycle(1, 32'h1000, 0, 0, 0, 1);
      repeat (2) drive_cycle(0, 0, 0, 1, 0, 1);
      drive_cycle(0, 0, 0, 1, 1, 1);
      settle();
      chk("fault_flag",  64'(bus_if.itlb_fault_o), 64'(1));
      chk("fault_pc",    64'(bus_if.fault_pc_o),   64'(32'h1008));
      chk("fault_count", 64'(bus_if.fq_count_o),   64'(2));
      repeat (2) drive_cycle(0, 0, 1, 1, 0, 1);
      settle();
      chk("fault_drained", 64'(bus_if.fq_count_o),   64'(0));
      chk("fault_sticky",  64'(bus_if.itlb_fault_o), 64'(1));
      drive_cycle(1, 32'h80, 1, 1, 0, 1);
      settle();
      chk("fault_cleared", 64'(bus_if.itlb_fault_o), 64'(0));
      drive_cycle(0, 0, 0, 1, 0, 1);
      settle();
      chk("fault_resume_pc", 64'(bus_if.inst_pc_o), 64'(32'h80));

      // Redirect in the same cycle as a pop of a full queue.
      drive_cycle(1, 32'h3000, 0, 0, 0, 1);
      repeat (4) drive_cycle(0, 0, 0, 1, 0, 1);
      settle();
      chk("full_count", 64'(bus_if.fq_count_o), 64'(4));
      drive_cycle(1, 32'h3100, 1, 1, 0, 1);
      settle();
      chk("flush_count", 64'(bus_if.fq_count_o),   64'(0));
      chk("flush_valid", 64'(bus_if.inst_valid_o), 64'(0));
      drive_cycle(0, 0, 1, 1, 0, 1);
      settle();
      chk("flush_next_pc", 64'(bus_if.inst_pc_o), 64'(32'h3100));

      // Randomized traffic against the reference model.
      rand_lat = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         red  = ($urandom_range(0, 99) < 4);
         rpc  = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
         rdy  = ($urandom_range(0, 3) != 0);
         trdy = ($urandom_range(0, 4) != 0);
         miss = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 99) < 2) line_v[16'(32'h100 + $urandom_range(0, 63))] = 1'b0;
         drive_cycle(red, rpc, rdy, trdy, miss, 0);
      end
      settle();
      chk("final_count", 64'(bus_if.fq_count_o), 64'(sb.size()));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
